// File: rtl/uart_port_tx_if.sv
// Core-side port bundle for the UART transmit stage: write strobe/data in,
// FIFO and line status out.
interface uart_port_tx_if;
    logic       PortWrite;
    logic [7:0] PortData;
    logic       FifoFull;
    logic       TxBusy;
    logic       Overflow;
    logic       TxSerial;

    modport master (
        output PortWrite, PortData,
        input  FifoFull, TxBusy, Overflow, TxSerial
    );

    modport slave (
        input  PortWrite, PortData,
        output FifoFull, TxBusy, Overflow, TxSerial
    );
endinterface

// File: rtl/uart_port_tx.sv
// Byte FIFO fed by the core's output-port strobe, drained as 8N1 UART frames.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits.
module uart_port_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input logic           clk,
    input logic           reset,
    uart_port_tx_if.slave port
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic              pop, push, full, baud_done;
`ifdef UART_PARITY_EN
    logic              par_q, par_d;
`endif

    always_comb begin
        full      = (count_q == CNT_FULL);
        pop       = (state_q == S_IDLE) && (count_q != '0);
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push      = port.PortWrite && (!full || pop);
        baud_done = (baud_q == BAUD_LAST);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (port.PortWrite && full && !pop);
        if (push) begin
            mem_d[wr_ptr_q] = port.PortData;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        state_d = state_q;
        baud_d  = baud_done ? '0 : baud_q + BAUD_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
                    par_d   = ^mem_q[rd_ptr_q];
`endif
                    state_d = S_START;
                end
            end
            S_START: if (baud_done) state_d = S_DATA;
            S_DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (baud_done) state_d = S_STOP;
`endif
            S_STOP: if (baud_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state one cycle late, giving a glitch-free output.
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q   <= mem_d;
        shift_q <= shift_d;
`ifdef UART_PARITY_EN
        par_q   <= par_d;
`endif
    end

    assign port.FifoFull = full;
    assign port.TxBusy   = (state_q != S_IDLE) || (count_q != '0);
    assign port.Overflow = ovf_q;
    assign port.TxSerial = tx_q;
endmodule

// File: tb/tb_uart_port_tx.sv
// Directed and randomized checks of uart_port_tx against a byte-queue model
// and a bit-level serial decoder.
module tb_uart_port_tx;
    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    logic [7:0] exp_q [$];
    logic       ovf_exp;

    uart_port_tx_if pif ();

    uart_port_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .port  (pif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        pif.PortData  = d;
        pif.PortWrite = 1'b1;
        tick();
    endtask

    // skip = cycles already elapsed since the start bit began (0 = wait for it)
    task automatic rx_frame(input int skip, output logic [7:0] b, output logic p, output int st);
        int n;
        int pos;
        n  = 0;
        b  = '0;
        p  = 1'b0;
        st = cyc;
        if (skip == 0) begin
            while (pif.TxSerial !== 1'b0 && n < 300) begin
                tick();
                n++;
            end
            chk("rx_start_seen", 32'(n < 300), 1);
            if (n >= 300) return;
        end
        st  = cyc - skip;
        pos = skip;
        if (pos < HALF) begin
            repeat (HALF - pos) tick();
            pos = HALF;
        end
        if (pos < CPB) chk("start_bit", 32'(pif.TxSerial), 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB * (i + 1) + HALF - pos) tick();
            pos  = CPB * (i + 1) + HALF;
            b[i] = pif.TxSerial;
        end
`ifdef UART_PARITY_EN
        repeat (CPB * 9 + HALF - pos) tick();
        pos = CPB * 9 + HALF;
        p   = pif.TxSerial;
`endif
        repeat (CPB * (FRAME_BITS - 1) + HALF - pos) tick();
        chk("stop_bit", 32'(pif.TxSerial), 1);
    endtask

    // Receive every queued byte in order, then confirm the port goes idle.
    task automatic drain(input int skip, input int prev_st);
        logic [7:0] b;
        logic [7:0] e;
        logic       p;
        int         st;
        int         prev;
        int         sk;
        prev = prev_st;
        sk   = skip;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rx_frame(sk, b, p, st);
            chk("rx_byte", 32'(b), 32'(e));
`ifdef UART_PARITY_EN
            chk("rx_parity", 32'(p), 32'(^e));
`endif
            if (prev >= 0) chk("frame_gap", st - prev, FRAME_BITS * CPB + 1);
            prev = st;
            sk   = 0;
        end
        chk("busy_in_stop", 32'(pif.TxBusy), 1);
        tick();
        chk("busy_fall", 32'(pif.TxBusy), 0);
        chk("line_idle", 32'(pif.TxSerial), 1);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        logic [7:0] e;
        logic       p;
        int         st;
        int         len;

        reset         = 1'b0;
        pif.PortWrite = 1'b0;
        pif.PortData  = '0;
        ovf_exp       = 1'b0;
        repeat (3) tick();
        chk("reset_line", 32'(pif.TxSerial), 1);
        chk("reset_busy", 32'(pif.TxBusy), 0);
        chk("reset_full", 32'(pif.FifoFull), 0);
        chk("reset_ovf",  32'(pif.Overflow), 0);
        @(negedge clk) reset = 1'b1;
        tick();

        // single byte latency and bit order
        write_byte(8'hA5);
        pif.PortWrite = 1'b0;
        chk("lat_n_line", 32'(pif.TxSerial), 1);
        chk("lat_n_busy", 32'(pif.TxBusy), 1);
        tick();
        chk("lat_n1_line", 32'(pif.TxSerial), 1);
        tick();
        chk("lat_n2_line", 32'(pif.TxSerial), 0);
        exp_q.push_back(8'hA5);
        drain(0, -1);

        // five consecutive writes: first pops early, the rest fill the FIFO
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            write_byte(d);
            exp_q.push_back(d);
        end
        pif.PortWrite = 1'b0;
        chk("burst5_full", 32'(pif.FifoFull), 1);
        chk("burst5_ovf",  32'(pif.Overflow), 0);
        drain(2, -1);

        // full FIFO written on the exact pop edge
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            write_byte(d);
            exp_q.push_back(d);
        end
        pif.PortWrite = 1'b0;
        e = exp_q.pop_front();
        rx_frame(2, b, p, st);
        chk("popedge_first", 32'(b), 32'(e));
        tick();
        chk("popedge_pre_full", 32'(pif.FifoFull), 1);
        d = 8'($urandom);
        write_byte(d);
        pif.PortWrite = 1'b0;
        exp_q.push_back(d);
        chk("popedge_full", 32'(pif.FifoFull), 1);
        chk("popedge_ovf",  32'(pif.Overflow), 0);
        drain(0, st);
        chk("popedge_ovf_end", 32'(pif.Overflow), 0);

        // fill behind an active frame, then overflow with 0x3C
        d = 8'($urandom);
        write_byte(d);
        exp_q.push_back(d);
        pif.PortWrite = 1'b0;
        tick();
        tick();
        chk("ovf_frame_active", 32'(pif.TxSerial), 0);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            write_byte(d);
            exp_q.push_back(d);
        end
        chk("ovf_pre_full", 32'(pif.FifoFull), 1);
        chk("ovf_pre_flag", 32'(pif.Overflow), 0);
        write_byte(8'h3C);
        pif.PortWrite = 1'b0;
        chk("ovf_flag", 32'(pif.Overflow), 1);
        drain(5, -1);
        chk("ovf_sticky", 32'(pif.Overflow), 1);

        // asynchronous reset in the middle of a data bit
        for (int i = 0; i < 5; i++) write_byte(8'($urandom));
        pif.PortWrite = 1'b0;
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        chk("midrst_line", 32'(pif.TxSerial), 1);
        chk("midrst_busy", 32'(pif.TxBusy), 0);
        chk("midrst_full", 32'(pif.FifoFull), 0);
        chk("midrst_ovf",  32'(pif.Overflow), 0);
        @(negedge clk) reset = 1'b1;
        repeat (50) tick();
        chk("postrst_line", 32'(pif.TxSerial), 1);
        chk("postrst_busy", 32'(pif.TxBusy), 0);
        ovf_exp = 1'b0;

`ifdef UART_PARITY_EN
        write_byte(8'h07);
        write_byte(8'h03);
        pif.PortWrite = 1'b0;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        drain(0, -1);
`endif

        // random bursts from idle: at most five bytes fit (one popped at once)
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 5)) tick();
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                d = 8'($urandom);
                write_byte(d);
                if (i < 5) exp_q.push_back(d);
            end
            pif.PortWrite = 1'b0;
            if (len > 5) ovf_exp = 1'b1;
            chk("rand_ovf", 32'(pif.Overflow), 32'(ovf_exp));
            drain((len >= 3) ? len - 3 : 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
